// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use hazard detection with minimum-stall, write-back wait,
// timeout and flush abort between the decode and execute stages.
module load_hazard_ctrl #(
    parameter int REG_AW    = 4,
    parameter int MIN_STALL = 1,
    parameter int MAX_WAIT  = 15,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] d_raddr1,
    input  logic [REG_AW-1:0] d_raddr2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic              d_immonly,
    input  logic              e_isLoad,
    input  logic [REG_AW-1:0] e_wreg,
    input  logic              write_done,
    input  logic              flush,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic              stall_active,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, STALL} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             done_seen_q, done_seen_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             hz, done_rel, to_rel, rel, hold;

    assign hz = e_isLoad & ~d_immonly & (e_wreg != '0) &
                ((d_use1 & (d_raddr1 == e_wreg)) | (d_use2 & (d_raddr2 == e_wreg)));
    assign done_rel = (cnt_q == 8'd0) & (write_done | done_seen_q);
    assign to_rel   = (wait_cnt_q == WW'(MAX_WAIT));
    assign rel      = flush | done_rel | to_rel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            wait_cnt_q     <= '0;
            done_seen_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            done_seen_q    <= done_seen_d;
            timeout_err_q  <= timeout_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_cnt_d     = wait_cnt_q;
        done_seen_d    = done_seen_q;
        timeout_err_d  = timeout_err_q;
        stall_cycles_d = (hold && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
        if (state_q == IDLE) begin
            if (hz && !flush) begin
                state_d     = STALL;
                cnt_d       = 8'(MIN_STALL - 1);
                wait_cnt_d  = WW'(1);
                done_seen_d = 1'b0;
            end
        end else if (rel) begin
            state_d       = IDLE;
            timeout_err_d = timeout_err_q | (to_rel & ~flush & ~done_rel);
        end else begin
            cnt_d       = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
            wait_cnt_d  = wait_cnt_q + WW'(1);
            done_seen_d = done_seen_q | write_done;
        end
    end

    // Release and detection are both same-cycle paths; reset forces everything low.
    always_comb begin
        hold         = ~rst & ((state_q == IDLE) ? (hz & ~flush) : ~rel);
        pc_stall     = hold;
        ifid_stall   = hold;
        idex_bubble  = hold;
        stall_active = (state_q == STALL);
        timeout_err  = timeout_err_q;
        stall_cycles = stall_cycles_q;
    end
endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb_load_hazard_ctrl: two configurations driven in parallel, checked against a
// stall-window reference model under directed and random stimulus.
module tb_load_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d_raddr1 = '0, d_raddr2 = '0, e_wreg = '0;
    logic       d_use1 = 0, d_use2 = 0, d_immonly = 0, e_isLoad = 0, write_done = 0, flush = 0;
    logic       pcs [2], ifs [2], idb [2], sact [2], terr [2];
    logic [15:0] sc_a;
    logic [3:0]  sc_b;
    int checks = 0, errors = 0;
    // model state per configuration: 0 = MIN 1/MAX 4/16-bit, 1 = MIN 3/MAX 6/4-bit
    int  mn [2] = '{1, 3};
    int  mx [2] = '{4, 6};
    int  cmax [2] = '{65535, 15};
    bit  m_in [2], m_seen [2], m_terr [2];
    int  m_k [2], m_sc [2];

    always #5 clk = ~clk;

    load_hazard_ctrl #(.REG_AW(4), .MIN_STALL(1), .MAX_WAIT(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .d_raddr1(d_raddr1), .d_raddr2(d_raddr2), .d_use1(d_use1),
        .d_use2(d_use2), .d_immonly(d_immonly), .e_isLoad(e_isLoad), .e_wreg(e_wreg),
        .write_done(write_done), .flush(flush), .pc_stall(pcs[0]), .ifid_stall(ifs[0]),
        .idex_bubble(idb[0]), .stall_active(sact[0]), .timeout_err(terr[0]), .stall_cycles(sc_a));

    load_hazard_ctrl #(.REG_AW(4), .MIN_STALL(3), .MAX_WAIT(6), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .d_raddr1(d_raddr1), .d_raddr2(d_raddr2), .d_use1(d_use1),
        .d_use2(d_use2), .d_immonly(d_immonly), .e_isLoad(e_isLoad), .e_wreg(e_wreg),
        .write_done(write_done), .flush(flush), .pc_stall(pcs[1]), .ifid_stall(ifs[1]),
        .idex_bubble(idb[1]), .stall_active(sact[1]), .timeout_err(terr[1]), .stall_cycles(sc_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int i, input bit st);
        logic [31:0] sc;
        sc = (i == 0) ? 32'(sc_a) : 32'(sc_b);
        check($sformatf("pc_stall[%0d]", i), 32'(pcs[i]), 32'(st));
        check($sformatf("ifid_stall[%0d]", i), 32'(ifs[i]), 32'(st));
        check($sformatf("idex_bubble[%0d]", i), 32'(idb[i]), 32'(st));
        check($sformatf("stall_active[%0d]", i), 32'(sact[i]), 32'(m_in[i]));
        check($sformatf("timeout_err[%0d]", i), 32'(terr[i]), 32'(m_terr[i]));
        check($sformatf("stall_cycles[%0d]", i), sc, 32'(m_sc[i]));
    endtask

    // Entered #1 after a rising edge; leaves #1 after the next one.
    task automatic step(input logic [3:0] r1, input logic [3:0] r2, input logic u1, input logic u2,
                        input logic im, input logic ld, input logic [3:0] w, input logic wd,
                        input logic fl);
        bit hz, rel, done_ok, st;
        d_raddr1 = r1; d_raddr2 = r2; d_use1 = u1; d_use2 = u2; d_immonly = im;
        e_isLoad = ld; e_wreg = w; write_done = wd; flush = fl;
        #3;
        hz = ld && !im && (w != 0) && ((u1 && r1 == w) || (u2 && r2 == w));
        for (int i = 0; i < 2; i++) begin
            done_ok = (m_k[i] >= mn[i]) && (wd || m_seen[i]);
            rel = fl || done_ok || (m_k[i] == mx[i]);
            st = m_in[i] ? !rel : (hz && !fl);
            check_dut(i, st);
            if (!m_in[i]) begin
                if (st) begin m_in[i] = 1; m_k[i] = 1; m_seen[i] = 0; end
            end else if (rel) begin
                m_in[i] = 0;
                if (!fl && !done_ok) m_terr[i] = 1;
            end else begin
                m_k[i]++;
                m_seen[i] |= wd;
            end
            if (st && m_sc[i] < cmax[i]) m_sc[i]++;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges: outputs must drop without waiting for a clock.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_in[i] = 0; m_seen[i] = 0; m_terr[i] = 0; m_k[i] = 0; m_sc[i] = 0;
            check_dut(i, 1'b0);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        // basic hazard on r5, write_done one cycle after detection
        step(5, 0, 1, 0, 0, 1, 5, 0, 0);
        step(5, 0, 1, 0, 0, 0, 5, 1, 0);
        idle(4);
        check("t1_cycles_a", 32'(sc_a), 32'd1);
        check("t1_cycles_b", 32'(sc_b), 32'd3);
        // non-hazards
        step(0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(7, 7, 1, 1, 1, 1, 7, 0, 0);
        step(1, 9, 1, 0, 0, 1, 9, 0, 0);
        step(9, 2, 0, 1, 0, 1, 9, 0, 0);
        step(9, 9, 1, 1, 0, 0, 9, 0, 0);
        check("t2_active_a", 32'(sact[0]), 32'd0);
        check("t2_cycles_a", 32'(sc_a), 32'd1);
        do_reset();
        // timeout, write_done never arrives
        step(0, 3, 0, 1, 0, 1, 3, 0, 0);
        idle(7);
        check("t4_terr_a", 32'(terr[0]), 32'd1);
        check("t4_terr_b", 32'(terr[1]), 32'd1);
        check("t4_cycles_a", 32'(sc_a), 32'd4);
        check("t4_cycles_b", 32'(sc_b), 32'd6);
        idle(3);
        check("t4_sticky_a", 32'(terr[0]), 32'd1);
        do_reset();
        // flush in the 2nd stall cycle, then flush in the detection cycle
        step(6, 0, 1, 0, 0, 1, 6, 0, 0);
        step(6, 0, 1, 0, 0, 0, 6, 0, 0);
        step(6, 0, 1, 0, 0, 0, 6, 1, 1);
        check("t5_active_b", 32'(sact[1]), 32'd0);
        check("t5_terr_b", 32'(terr[1]), 32'd0);
        step(4, 0, 1, 0, 0, 1, 4, 0, 1);
        idle(2);
        check("t5_cycles_b", 32'(sc_b), 32'd2);
        // reset mid-stall, then a fresh hazard
        step(2, 2, 1, 1, 0, 1, 2, 0, 0);
        step(2, 2, 1, 1, 0, 0, 2, 0, 0);
        do_reset();
        step(2, 2, 1, 1, 0, 1, 2, 0, 0);
        check("t6_active_a", 32'(sact[0]), 32'd1);
        idle(8);
        // random stimulus with a narrow register range to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
